// File: rtl/pll_acq_ctrl.sv
// PLL acquisition/lock sequencer: reset hold, open-loop run, closed-loop tracking, lock qualification.
// Optional reference-loss timer is built when PLL_ACQ_TIMEOUT_EN is defined.
//
// state  | meaning
// IDLE   | PLL held in reset, waiting for swipt_alive
// OPEN   | PLL running open-loop at f0 for OPEN_EDGES reference edges
// TRACK  | closed-loop, counting consecutive in-window edges
// LOCKED | lock qualified, counting consecutive out-of-window edges
// RELOCK | one cycle: retry accounting
// FAULT  | retries exhausted, PLL held in reset until clr_fault
module pll_acq_ctrl #(
   parameter int unsigned F0           = 40000,
   parameter int unsigned F_TOL        = 2000,
   parameter int unsigned OPEN_EDGES   = 8,
   parameter int unsigned LOCK_EDGES   = 16,
   parameter int unsigned UNLOCK_EDGES = 4,
   parameter int unsigned MAX_RETRY    = 3
`ifdef PLL_ACQ_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYC  = 10000
`endif
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        swipt_alive,
   input  logic        link,
   input  logic [31:0] f_in,
   input  logic        clr_fault,
   output logic        pll_nrst,
   output logic        freq_rdy,
   output logic        locked,
   output logic        fault,
   output logic [2:0]  state,
   output logic [1:0]  retry_cnt
);

   localparam int unsigned MAX_OL   = (OPEN_EDGES > LOCK_EDGES) ? OPEN_EDGES : LOCK_EDGES;
   localparam int unsigned EDGE_MAX = (MAX_OL > UNLOCK_EDGES) ? MAX_OL : UNLOCK_EDGES;
   localparam int          CNT_W    = $clog2(EDGE_MAX + 1);

   localparam logic [31:0]      F0_W      = 32'(F0);
   localparam logic [31:0]      TOL_W     = 32'(F_TOL);
   localparam logic [CNT_W-1:0] OPEN_N    = CNT_W'(OPEN_EDGES);
   localparam logic [CNT_W-1:0] LOCK_N    = CNT_W'(LOCK_EDGES);
   localparam logic [CNT_W-1:0] UNLOCK_N  = CNT_W'(UNLOCK_EDGES);
   localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRY);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_OPEN   = 3'd1,
      S_TRACK  = 3'd2,
      S_LOCKED = 3'd3,
      S_RELOCK = 3'd4,
      S_FAULT  = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [1:0]       retry_q, retry_d;
   logic             link_s1, link_s2, link_s3, link_edge;
   logic [31:0]      f_diff;
   logic             in_win;
   logic             timeout;

   // Registered edge pulse: a link transition appears on link_edge three clocks later.
   always_ff @(posedge clk) begin
      if (nrst) begin
         link_s1   <= 1'b0;
         link_s2   <= 1'b0;
         link_s3   <= 1'b0;
         link_edge <= 1'b0;
      end else begin
         link_s1   <= link;
         link_s2   <= link_s1;
         link_s3   <= link_s2;
         link_edge <= link_s2 & ~link_s3;
      end
   end

   assign f_diff  = (f_in >= F0_W) ? (f_in - F0_W) : (F0_W - f_in);
   assign in_win  = (f_diff <= TOL_W);
   assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef PLL_ACQ_TIMEOUT_EN
   localparam logic [31:0] TMO_W = 32'(TIMEOUT_CYC);
   logic [31:0] timer_q;

   // Also held in RELOCK so each new attempt gets a full window.
   always_ff @(posedge clk) begin
      if (nrst) begin
         timer_q <= '0;
      end else if ((state_q inside {S_IDLE, S_FAULT, S_RELOCK}) || link_edge) begin
         timer_q <= '0;
      end else if (timer_q != '1) begin
         timer_q <= timer_q + 32'd1;
      end
   end

   assign timeout = (timer_q >= TMO_W) && (state_q inside {S_OPEN, S_TRACK, S_LOCKED});
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (nrst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         retry_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         retry_q <= retry_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      retry_d = retry_q;
      if ((state_q != S_IDLE) && !swipt_alive) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         retry_d = '0;
      end else if (timeout) begin
         state_d = S_RELOCK;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               cnt_d   = '0;
               retry_d = '0;
               if (swipt_alive) state_d = S_OPEN;
            end
            S_OPEN: begin
               if (link_edge) begin
                  if (cnt_inc == OPEN_N) begin
                     state_d = S_TRACK;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end
            end
            S_TRACK: begin
               if (link_edge) begin
                  if (!in_win) begin
                     cnt_d = '0;
                  end else if (cnt_inc == LOCK_N) begin
                     state_d = S_LOCKED;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end
            end
            S_LOCKED: begin
               if (link_edge) begin
                  if (in_win) begin
                     cnt_d = '0;
                  end else if (cnt_inc == UNLOCK_N) begin
                     state_d = S_RELOCK;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end
            end
            S_RELOCK: begin
               cnt_d = '0;
               if (retry_q == RETRY_MAX) begin
                  state_d = S_FAULT;
               end else begin
                  retry_d = retry_q + 2'd1;
                  state_d = S_OPEN;
               end
            end
            S_FAULT: begin
               if (clr_fault) begin
                  state_d = S_IDLE;
                  retry_d = '0;
               end
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = '0;
               retry_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (nrst) begin
         pll_nrst <= 1'b0;
         freq_rdy <= 1'b0;
         locked   <= 1'b0;
         fault    <= 1'b0;
      end else begin
         pll_nrst <= (state_q != S_IDLE) && (state_q != S_FAULT);
         freq_rdy <= (state_q == S_OPEN);
         locked   <= (state_q == S_LOCKED);
         fault    <= (state_q == S_FAULT);
      end
   end

   assign state     = state_q;
   assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_acq_ctrl.sv
// Scoreboard bench for pll_acq_ctrl: an edge-level reference model pushes the expected
// state/outputs per link pulse; each scenario task pops and compares once the pulse settles.
module tb_pll_acq_ctrl;

   logic        clk = 1'b0;
   logic        nrst, swipt_alive, link, clr_fault;
   logic [31:0] f_in;
   logic        pll_nrst, freq_rdy, locked, fault;
   logic [2:0]  state;
   logic [1:0]  retry_cnt;
   logic [8:0]  obs;

   int n_vec = 0;
   int n_err = 0;

   logic [2:0] m_state;
   logic [1:0] m_retry;
   int         m_cnt;
   logic [8:0] sb_q[$];

   always #5 clk = ~clk;

   pll_acq_ctrl dut (
      .clk         (clk),
      .nrst        (nrst),
      .swipt_alive (swipt_alive),
      .link        (link),
      .f_in        (f_in),
      .clr_fault   (clr_fault),
      .pll_nrst    (pll_nrst),
      .freq_rdy    (freq_rdy),
      .locked      (locked),
      .fault       (fault),
      .state       (state),
      .retry_cnt   (retry_cnt)
   );

   assign obs = {state, retry_cnt, pll_nrst, freq_rdy, locked, fault};

   function automatic logic [8:0] pack_exp(input logic [2:0] s, input logic [1:0] r);
      return {s, r, !(s == 3'd0 || s == 3'd5), (s == 3'd1), (s == 3'd3), (s == 3'd5)};
   endfunction

   function automatic bit tb_in_win(input logic [31:0] f);
      longint d;
      d = longint'(f) - 64'sd40000;
      if (d < 0) d = -d;
      return (d <= 64'sd2000);
   endfunction

   task automatic model_relock();
      if (m_retry == 2'd3) begin
         m_state = 3'd5;
      end else begin
         m_retry = m_retry + 2'd1;
         m_state = 3'd1;
      end
      m_cnt = 0;
   endtask

   task automatic model_edge(input logic [31:0] f);
      bit inw;
      inw = tb_in_win(f);
      case (m_state)
         3'd1: begin
            m_cnt++;
            if (m_cnt == 8) begin m_state = 3'd2; m_cnt = 0; end
         end
         3'd2: begin
            if (!inw) m_cnt = 0;
            else begin
               m_cnt++;
               if (m_cnt == 16) begin m_state = 3'd3; m_cnt = 0; end
            end
         end
         3'd3: begin
            if (inw) m_cnt = 0;
            else begin
               m_cnt++;
               if (m_cnt == 4) model_relock();
            end
         end
         default: ;
      endcase
   endtask

   // One reference period of 20 clocks, f_in held across it; link changes off the clock edges.
   task automatic drive_edge(input logic [31:0] f);
      model_edge(f);
      sb_q.push_back(pack_exp(m_state, m_retry));
      @(negedge clk);
      #2;
      f_in = f;
      link = 1'b1;
      repeat (10) @(negedge clk);
      #2;
      link = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_reset();
      logic [8:0] exp;
      nrst = 1'b1; swipt_alive = 1'b1; link = 1'b0; clr_fault = 1'b0; f_in = 32'd40000;
      repeat (5) @(negedge clk);
      exp = 9'd0;
      n_vec++;
      if (obs !== exp) begin n_err++; $display("FAIL reset_hold: got %h want %h", obs, exp); end
      nrst = 1'b0; swipt_alive = 1'b0;
      repeat (3) @(negedge clk);
      n_vec++;
      if (obs !== exp) begin n_err++; $display("FAIL idle_no_alive: got %h want %h", obs, exp); end
      m_state = 3'd0; m_retry = 2'd0; m_cnt = 0;
   endtask

   task automatic test_acquire();
      logic [8:0] exp;
      swipt_alive = 1'b1;
      @(negedge clk);
      n_vec++;
      if (state !== 3'd1) begin n_err++; $display("FAIL idle_to_open: got %0d want 1", state); end
      @(negedge clk);
      exp = pack_exp(3'd1, 2'd0);
      n_vec++;
      if (obs !== exp) begin n_err++; $display("FAIL open_outputs: got %h want %h", obs, exp); end
      m_state = 3'd1; m_cnt = 0;
      for (int i = 0; i < 24; i++) begin
         drive_edge(32'd40000);
         exp = sb_q.pop_front();
         n_vec++;
         if (obs !== exp) begin n_err++; $display("FAIL acquire[%0d]: got %h want %h", i, obs, exp); end
      end
   endtask

   task automatic test_lose_lock();
      logic [8:0] exp;
      for (int i = 0; i < 28; i++) begin
         drive_edge((i < 4) ? 32'd45000 : 32'd40000);
         exp = sb_q.pop_front();
         n_vec++;
         if (obs !== exp) begin n_err++; $display("FAIL lose_lock[%0d]: got %h want %h", i, obs, exp); end
      end
   endtask

   task automatic test_swipt_drop();
      swipt_alive = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({state, retry_cnt} !== 5'd0) begin
         n_err++; $display("FAIL swipt_drop_state: got %h want 00", {state, retry_cnt});
      end
      @(negedge clk);
      n_vec++;
      if (obs !== 9'd0) begin n_err++; $display("FAIL swipt_drop_outputs: got %h want 000", obs); end
      m_state = 3'd0; m_retry = 2'd0; m_cnt = 0;
   endtask

   task automatic test_restart();
      logic [8:0]  exp;
      logic [31:0] f;
      swipt_alive = 1'b1;
      @(negedge clk);
      n_vec++;
      if (state !== 3'd1) begin n_err++; $display("FAIL restart_open: got %0d want 1", state); end
      m_state = 3'd1; m_cnt = 0;
      for (int i = 0; i < 34; i++) begin
         if (i < 17)       f = 32'd40000;
         else if (i == 17) f = 32'd42001;
         else              f = 32'd41000;
         drive_edge(f);
         exp = sb_q.pop_front();
         n_vec++;
         if (obs !== exp) begin n_err++; $display("FAIL restart[%0d]: got %h want %h", i, obs, exp); end
      end
   endtask

   task automatic test_fault();
      logic [8:0] exp;
      clr_fault = 1'b1;
      @(negedge clk);
      clr_fault = 1'b0;
      @(negedge clk);
      exp = pack_exp(m_state, m_retry);
      n_vec++;
      if (obs !== exp) begin n_err++; $display("FAIL clr_ignored: got %h want %h", obs, exp); end
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 28; i++) begin
            if (k == 3 && i >= 4) break;
            drive_edge((i < 4) ? 32'd45000 : 32'd40000);
            exp = sb_q.pop_front();
            n_vec++;
            if (obs !== exp) begin n_err++; $display("FAIL retry%0d[%0d]: got %h want %h", k, i, obs, exp); end
         end
      end
      for (int i = 0; i < 2; i++) begin
         drive_edge(32'd40000);
         exp = sb_q.pop_front();
         n_vec++;
         if (obs !== exp) begin n_err++; $display("FAIL fault_hold[%0d]: got %h want %h", i, obs, exp); end
      end
      clr_fault = 1'b1;
      @(negedge clk);
      clr_fault = 1'b0;
      n_vec++;
      if ({state, retry_cnt} !== 5'd0) begin
         n_err++; $display("FAIL clr_fault_idle: got %h want 00", {state, retry_cnt});
      end
      @(negedge clk);
      n_vec++;
      if ({state, fault} !== 4'b0010) begin
         n_err++; $display("FAIL clr_fault_reopen: got %h want 2", {state, fault});
      end
      m_state = 3'd1; m_retry = 2'd0; m_cnt = 0;
   endtask

   task automatic test_boundary();
      logic [8:0]  exp;
      logic [31:0] pat [12];
      pat = '{32'd37999, 32'd42001, 32'd0, 32'd38000,
              32'hFFFF_FFFF, 32'd37999, 32'd42001, 32'd42000,
              32'd0, 32'hFFFF_FFFF, 32'd37999, 32'd42001};
      for (int i = 0; i < 24; i++) begin
         drive_edge((i < 8) ? 32'd40000 : ((i % 2 == 0) ? 32'd38000 : 32'd42000));
         exp = sb_q.pop_front();
         n_vec++;
         if (obs !== exp) begin n_err++; $display("FAIL edge_lock[%0d]: got %h want %h", i, obs, exp); end
      end
      for (int i = 0; i < 12; i++) begin
         drive_edge(pat[i]);
         exp = sb_q.pop_front();
         n_vec++;
         if (obs !== exp) begin n_err++; $display("FAIL window[%0d]: got %h want %h", i, obs, exp); end
      end
   endtask

   task automatic test_timeout();
      logic [8:0] exp;
      int waited;
      for (int i = 0; i < 24; i++) begin
         drive_edge(32'd40000);
         exp = sb_q.pop_front();
         n_vec++;
         if (obs !== exp) begin n_err++; $display("FAIL tmo_lock[%0d]: got %h want %h", i, obs, exp); end
      end
      waited = 0;
      while (state == 3'd3 && waited < 10100) begin
         @(negedge clk);
         waited++;
      end
`ifdef PLL_ACQ_TIMEOUT_EN
      n_vec++;
      if (waited < 9950 || waited > 10030) begin
         n_err++; $display("FAIL timeout_delay: got %0d cycles want 9950..10030", waited);
      end
      repeat (2) @(negedge clk);
      model_relock();
`endif
      exp = pack_exp(m_state, m_retry);
      n_vec++;
      if (obs !== exp) begin n_err++; $display("FAIL timeout_state: got %h want %h", obs, exp); end
   endtask

   task automatic test_reset_mid();
      nrst = 1'b1;
      @(negedge clk);
      n_vec++;
      if (obs !== 9'd0) begin n_err++; $display("FAIL mid_reset: got %h want 000", obs); end
      nrst = 1'b0;
      @(negedge clk);
      n_vec++;
      if (state !== 3'd1) begin n_err++; $display("FAIL post_reset_open: got %0d want 1", state); end
   endtask

   initial begin
      test_reset();
      test_acquire();
      test_lose_lock();
      test_swipt_drop();
      test_restart();
      test_fault();
      test_boundary();
      test_timeout();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
